// File: rtl/event_rate_pkg.sv
// Shared definitions for the event-rate scheduler: register map, field
// positions and the scheduler FSM encoding.
package event_rate_pkg;

   localparam logic [7:0] ADDR_CTRL       = 8'h00;
   localparam logic [7:0] ADDR_PERIOD     = 8'h04;
   localparam logic [7:0] ADDR_STATUS     = 8'h08;
   localparam logic [7:0] ADDR_DELTA_BASE = 8'h10;

   localparam int CTRL_ENABLE_BIT  = 0;
   localparam int CTRL_ONESHOT_BIT = 1;
   localparam int CTRL_RESTART_BIT = 2;

   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_OVERRUN_BIT = 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRIME   = 3'd1,
      ST_RUN     = 3'd2,
      ST_SCAN    = 3'd3,
      ST_PUBLISH = 3'd4
   } state_t;

endpackage

// File: rtl/window_timer.sv
// Gap-free window timer: down-counter reloaded with period-1 on load and at
// every boundary; a boundary is the cycle the running counter reads zero.
module window_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_period,
   input  logic        i_load,
   input  logic        i_run,
   output logic        o_boundary
);

   logic [31:0] r_timer;

   assign o_boundary = i_run && !i_load && (r_timer == 32'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer <= 32'd0;
      end else if (i_load || o_boundary) begin
         r_timer <= i_period - 32'd1;
      end else if (i_run) begin
         r_timer <= r_timer - 32'd1;
      end else begin
         r_timer <= r_timer;
      end
   end

endmodule

// File: rtl/event_rate_scheduler.sv
// Turns free-running 32-bit event counts into per-window deltas: atomic
// snapshot at each boundary, one shared subtractor walked over the channels.
module event_rate_scheduler
   import event_rate_pkg::*;
#(
   parameter int          CHANNELS     = 8,
   parameter logic [31:0] PERIOD_RESET = 32'd1000000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              i_reg_addr,
   input  logic                    i_reg_wr,
   input  logic [31:0]             i_reg_wdata,
   input  logic                    i_reg_rd,
   output logic [31:0]             o_reg_rdata,
   output logic                    o_reg_rvalid,
   input  logic [32*CHANNELS-1:0]  counts,
   output logic                    window_strobe
);

   localparam int             IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [IW-1:0]  IDX_LAST = IW'(CHANNELS - 1);
   localparam logic [5:0]     CH_W     = 6'(CHANNELS);

   state_t        r_state, w_state_next;
   logic          r_enable, r_oneshot, r_overrun, r_strobe, r_rvalid;
   logic [31:0]   r_period, r_rdata;
   logic [15:0]   r_seq;
   logic [IW-1:0] r_idx;
   logic [31:0]   r_snap   [CHANNELS];
   logic [31:0]   r_prev   [CHANNELS];
   logic [31:0]   r_shadow [CHANNELS];
   logic [31:0]   r_delta  [CHANNELS];

   logic          w_wr_ctrl, w_wr_period, w_wr_status, w_restart, w_en_eff;
   logic          w_load, w_run, w_boundary;
   logic [31:0]   w_diff, w_rd_data;
   logic [5:0]    w_delta_word;

   assign w_wr_ctrl   = i_reg_wr && (i_reg_addr == ADDR_CTRL);
   assign w_wr_period = i_reg_wr && (i_reg_addr == ADDR_PERIOD);
   assign w_wr_status = i_reg_wr && (i_reg_addr == ADDR_STATUS);
   assign w_restart   = w_wr_ctrl && i_reg_wdata[CTRL_RESTART_BIT];
   // A software clear of ENABLE acts in the write cycle so the FSM is IDLE next cycle.
   assign w_en_eff    = w_wr_ctrl ? i_reg_wdata[CTRL_ENABLE_BIT] : r_enable;
   assign w_run       = (r_state != ST_IDLE);
   assign w_load      = w_en_eff && (((r_state == ST_IDLE) && (r_period != 32'd0)) ||
                                     ((r_state != ST_IDLE) && w_restart));
   assign w_diff      = r_snap[r_idx] - r_prev[r_idx];

   window_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_period   (r_period),
      .i_load     (w_load),
      .i_run      (w_run),
      .o_boundary (w_boundary)
   );

   always_comb begin
      w_state_next = r_state;
      if (!w_en_eff) begin
         w_state_next = ST_IDLE;
      end else if (w_load) begin
         w_state_next = ST_PRIME;
      end else begin
         case (r_state)
            ST_IDLE:    w_state_next = ST_IDLE;
            ST_PRIME:   w_state_next = w_boundary ? ST_RUN : ST_PRIME;
            ST_RUN:     w_state_next = w_boundary ? ST_SCAN : ST_RUN;
            ST_SCAN:    w_state_next = (r_idx == IDX_LAST) ? ST_PUBLISH : ST_SCAN;
            ST_PUBLISH: w_state_next = r_oneshot ? ST_IDLE : ST_RUN;
            default:    w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_strobe  <= 1'b0;
         r_enable  <= 1'b0;
         r_oneshot <= 1'b0;
         r_period  <= PERIOD_RESET;
         r_overrun <= 1'b0;
         r_seq     <= 16'd0;
      end else begin
         r_state  <= w_state_next;
         r_strobe <= (w_state_next == ST_PUBLISH);
         if ((r_state == ST_PUBLISH) && r_oneshot) begin
            r_enable <= 1'b0;
         end else if (w_wr_ctrl) begin
            r_enable <= i_reg_wdata[CTRL_ENABLE_BIT];
         end
         if (w_wr_ctrl) begin
            r_oneshot <= i_reg_wdata[CTRL_ONESHOT_BIT];
         end
         if (w_wr_period) begin
            r_period <= i_reg_wdata;
         end
         // Boundaries landing in SCAN/PUBLISH are dropped; the overrun set beats a clear.
         if (w_boundary && ((r_state == ST_SCAN) || (r_state == ST_PUBLISH))) begin
            r_overrun <= 1'b1;
         end else if (w_wr_status && i_reg_wdata[STAT_OVERRUN_BIT]) begin
            r_overrun <= 1'b0;
         end
         if (r_state == ST_PUBLISH) begin
            r_seq <= r_seq + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            r_snap[i]   <= 32'd0;
            r_prev[i]   <= 32'd0;
            r_shadow[i] <= 32'd0;
            r_delta[i]  <= 32'd0;
         end
      end else if ((r_state == ST_PRIME) && (w_state_next == ST_RUN)) begin
         for (int i = 0; i < CHANNELS; i++) r_prev[i] <= counts[32*i +: 32];
      end else if ((r_state == ST_RUN) && (w_state_next == ST_SCAN)) begin
         for (int i = 0; i < CHANNELS; i++) r_snap[i] <= counts[32*i +: 32];
         r_idx <= '0;
      end else if (r_state == ST_SCAN) begin
         r_shadow[r_idx] <= w_diff;
         r_prev[r_idx]   <= r_snap[r_idx];
         r_idx           <= r_idx + IW'(1);
      end else if (r_state == ST_PUBLISH) begin
         for (int i = 0; i < CHANNELS; i++) r_delta[i] <= r_shadow[i];
      end
   end

   assign w_delta_word = i_reg_addr[7:2] - 6'd4;

   always_comb begin
      w_rd_data = 32'd0;
      case (i_reg_addr)
         ADDR_CTRL:   w_rd_data = {30'd0, r_oneshot, r_enable};
         ADDR_PERIOD: w_rd_data = r_period;
         ADDR_STATUS: w_rd_data = {r_seq, 14'd0, r_overrun, w_run};
         default: begin
            if ((i_reg_addr >= ADDR_DELTA_BASE) && (w_delta_word < CH_W)) begin
               w_rd_data = r_delta[w_delta_word[IW-1:0]];
            end else begin
               w_rd_data = 32'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata  <= 32'd0;
         r_rvalid <= 1'b0;
      end else begin
         r_rdata  <= i_reg_rd ? w_rd_data : 32'd0;
         r_rvalid <= i_reg_rd;
      end
   end

   assign o_reg_rdata   = r_rdata;
   assign o_reg_rvalid  = r_rvalid;
   assign window_strobe = r_strobe;

endmodule

// File: tb/tb_event_rate_scheduler.sv
// Randomized self-checking bench: counts are base+rate*cycle, so every
// expected delta is plain arithmetic over the predicted capture cycles.
module tb_event_rate_scheduler;

   localparam int          CH     = 8;
   localparam logic [31:0] PRST   = 32'd1000000;
   localparam logic [7:0]  A_CTRL = 8'h00, A_PERIOD = 8'h04, A_STATUS = 8'h08, A_DELTA = 8'h10;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        i_reg_addr;
   logic              i_reg_wr, i_reg_rd;
   logic [31:0]       i_reg_wdata, o_reg_rdata;
   logic              o_reg_rvalid, window_strobe;
   logic [32*CH-1:0]  counts;

   logic [31:0] cyc = 32'd0;
   logic [31:0] base [CH];
   logic [31:0] rate [CH];
   logic [31:0] g_delta [CH];
   logic [15:0] g_seq;
   logic        g_ov;
   int          g_cap;
   int          n_checks = 0, n_fail = 0, strobe_cnt = 0, n0;
   logic [31:0] rd;

   event_rate_scheduler #(.CHANNELS(CH), .PERIOD_RESET(PRST)) dut (
      .clk(clk), .rst(rst), .i_reg_addr(i_reg_addr), .i_reg_wr(i_reg_wr),
      .i_reg_wdata(i_reg_wdata), .i_reg_rd(i_reg_rd), .o_reg_rdata(o_reg_rdata),
      .o_reg_rvalid(o_reg_rvalid), .counts(counts), .window_strobe(window_strobe)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 32'd1;
   always @(negedge clk) if (window_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

   initial begin
      counts = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < CH; i++) counts[32*i +: 32] = base[i] + rate[i] * cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] cnt(input int c, input int t);
      return base[c] + rate[c] * 32'(t);
   endfunction

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      i_reg_addr = a; i_reg_wdata = d; i_reg_wr = 1'b1;
      @(negedge clk);
      i_reg_wr = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      i_reg_addr = a; i_reg_rd = 1'b1;
      @(negedge clk);
      d = o_reg_rdata;
      i_reg_rd = 1'b0;
   endtask

   task automatic new_counts();
      for (int i = 0; i < CH; i++) begin
         base[i] = $urandom;
         rate[i] = (i % 3 == 2) ? $urandom : $urandom_range(0, 2000);
      end
   endtask

   task automatic check_reset_regs(input string tag);
      check_eq({tag, "_strobe"}, 32'(window_strobe), 32'd0);
      bus_read(A_CTRL, rd);   check_eq({tag, "_ctrl"}, rd, 32'd0);
      bus_read(A_PERIOD, rd); check_eq({tag, "_period"}, rd, PRST);
      bus_read(A_STATUS, rd); check_eq({tag, "_status"}, rd, 32'd0);
      for (int c = 0; c < CH; c++) begin
         bus_read(A_DELTA + 8'(4*c), rd); check_eq({tag, "_delta"}, rd, 32'd0);
      end
   endtask

   // Enable with period p and follow nwin publishes; captures are the boundaries
   // ten+k*p that are not within CH+1 cycles after the previous capture.
   task automatic run_windows(input int p, input int nwin, input logic [31:0] ctrl_val);
      int ten, prev, cap, s, nread, k;
      bus_write(A_PERIOD, 32'(p));
      ten = int'(cyc);
      bus_write(A_CTRL, ctrl_val);
      prev = ten + p;
      cap  = ten + 2 * p;
      for (int w = 0; w < nwin; w++) begin
         s = cap + CH + 1;
         while (int'(cyc) < s - 1) @(negedge clk);
         check_eq("strobe_pre", 32'(window_strobe), 32'd0);
         @(negedge clk);
         check_eq("strobe", 32'(window_strobe), 32'd1);
         g_seq = g_seq + 16'd1;
         if (p <= CH + 1) g_ov = 1'b1;
         for (int c = 0; c < CH; c++) g_delta[c] = cnt(c, cap) - cnt(c, prev);
         @(negedge clk);
         nread = (p > 10) ? CH : 4;
         for (int c = 0; c < nread; c++) begin
            bus_read(A_DELTA + 8'(4*c), rd);
            check_eq($sformatf("delta%0d_p%0d", c, p), rd, g_delta[c]);
         end
         bus_read(A_STATUS, rd);
         check_eq("seq", {16'd0, rd[31:16]}, {16'd0, g_seq});
         check_eq("overrun", {31'd0, rd[1]}, {31'd0, g_ov});
         check_eq("busy", {31'd0, rd[0]}, {31'd0, ~ctrl_val[1]});
         prev = cap;
         k    = (cap + CH + 2 - ten + p - 1) / p;
         cap  = ten + k * p;
      end
      g_cap = cap;
   endtask

   initial begin
      rst = 1'b1; i_reg_wr = 1'b0; i_reg_rd = 1'b0; i_reg_addr = 8'd0; i_reg_wdata = 32'd0;
      for (int i = 0; i < CH; i++) begin base[i] = 32'd0; rate[i] = 32'd0; g_delta[i] = 32'd0; end
      g_seq = 16'd0; g_ov = 1'b0; g_cap = 0;
      repeat (3) @(negedge clk);
      check_eq("in_reset_strobe", 32'(window_strobe), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_reset_regs("init");

      // steady rate 3 on channel 0, wrap through 0xFFFFFFF0 on channel 1
      new_counts();
      rate[0] = 32'd3;
      rate[1] = 32'd7;
      base[1] = 32'hFFFFFFF0 - 32'd7 * (cyc + 32'd160);
      run_windows(100, 3, 32'd1);
      bus_read(A_DELTA, rd);          check_eq("delta0_300", rd, 32'd300);
      bus_read(A_DELTA + 8'd32, rd);  check_eq("delta_oob", rd, 32'd0);
      bus_write(A_CTRL, 32'd0);

      for (int k = 0; k < 3; k++) begin
         new_counts();
         run_windows(int'($urandom_range(12, 60)), 2, 32'd1);
         bus_write(A_CTRL, 32'd0);
      end

      // overrun: period 5, then sticky clear, then the CH+1 / CH+2 boundaries
      new_counts();
      run_windows(5, 3, 32'd1);
      bus_write(A_CTRL, 32'd0);
      bus_write(A_STATUS, 32'h2);
      g_ov = 1'b0;
      bus_read(A_STATUS, rd);
      check_eq("ov_cleared", {30'd0, rd[1:0]}, 32'd0);
      new_counts();
      run_windows(10, 2, 32'd1);
      bus_write(A_CTRL, 32'd0);
      new_counts();
      run_windows(9, 2, 32'd1);
      bus_write(A_CTRL, 32'd0);
      bus_write(A_STATUS, 32'h2);
      g_ov = 1'b0;

      // oneshot
      new_counts();
      n0 = strobe_cnt;
      run_windows(50, 1, 32'd3);
      repeat (150) @(negedge clk);
      check_eq("oneshot_count", 32'(strobe_cnt - n0), 32'd1);
      bus_read(A_CTRL, rd);   check_eq("oneshot_ctrl", rd, 32'h2);
      bus_read(A_STATUS, rd); check_eq("oneshot_busy", {31'd0, rd[0]}, 32'd0);
      bus_read(A_DELTA, rd);  check_eq("oneshot_held", rd, g_delta[0]);
      bus_write(A_CTRL, 32'd0);

      // abort at SCAN idx=3 of the next window
      new_counts();
      run_windows(30, 1, 32'd1);
      n0 = strobe_cnt;
      while (int'(cyc) < g_cap + 4) @(negedge clk);
      bus_write(A_CTRL, 32'd0);
      bus_read(A_STATUS, rd);
      check_eq("abort_busy", {31'd0, rd[0]}, 32'd0);
      check_eq("abort_seq", {16'd0, rd[31:16]}, {16'd0, g_seq});
      repeat (40) @(negedge clk);
      check_eq("abort_nostrobe", 32'(strobe_cnt - n0), 32'd0);
      for (int c = 0; c < 4; c++) begin
         bus_read(A_DELTA + 8'(4*c), rd); check_eq("abort_delta", rd, g_delta[c]);
      end

      // async reset in the PUBLISH cycle, then prime again
      new_counts();
      run_windows(20, 1, 32'd1);
      while (int'(cyc) < g_cap + CH + 1) @(negedge clk);
      check_eq("pub_strobe", 32'(window_strobe), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_strobe_low", 32'(window_strobe), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      g_seq = 16'd0; g_ov = 1'b0;
      check_reset_regs("after_rst");
      new_counts();
      run_windows(20, 1, 32'd1);
      bus_write(A_CTRL, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
